// File: rtl/mem_arb.sv
// Single-port memory arbiter: grants the IF or LS requester and runs one outstanding
// memory transaction at a time. Responses are routed back to the owner, with a timeout abort.
module mem_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int LS_PRIO = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_if_valid,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_ready,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_err,
   input  logic                i_ls_valid,
   input  logic [ADDR_W-1:0]   i_ls_addr,
   input  logic                i_ls_wen,
   input  logic [DATA_W-1:0]   i_ls_wdata,
   input  logic [DATA_W/8-1:0] i_ls_wmask,
   output logic                o_ls_ready,
   output logic                o_ls_rvalid,
   output logic [DATA_W-1:0]   o_ls_rdata,
   output logic                o_ls_err,
   output logic                o_mem_req,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic                o_mem_wen,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_wmask,
   input  logic                i_mem_ack,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_nxt;
   logic               grant_if, grant_ls;
   logic               owner_ls;
   logic               last_ls;
   logic [CNT_W-1:0]   cnt;
   logic               timeout_hit;
   logic               done;
   logic [DATA_W-1:0]  rsp_rdata;

   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));
   assign done        = i_mem_ack || timeout_hit;
   // Stores and timeouts return zero data; ack beats a same-cycle timeout.
   assign rsp_rdata   = (i_mem_ack && !o_mem_wen) ? i_mem_rdata : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_if || grant_ls) state_nxt = BUSY;
         BUSY:    if (done)                 state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   // Ready is the grant itself; round-robin favours the port not granted last.
   always_comb begin
      grant_ls = 1'b0;
      grant_if = 1'b0;
      if (state == IDLE) begin
         grant_ls = i_ls_valid && ((LS_PRIO != 0) || !i_if_valid || !last_ls);
         grant_if = i_if_valid && !grant_ls;
      end
      o_ls_ready = grant_ls;
      o_if_ready = grant_if;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mem_req   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wen   <= 1'b0;
         o_mem_wdata <= '0;
         o_mem_wmask <= '0;
         owner_ls    <= 1'b0;
         last_ls     <= 1'b0;
         cnt         <= '0;
         o_if_rvalid <= 1'b0;
         o_if_rdata  <= '0;
         o_if_err    <= 1'b0;
         o_ls_rvalid <= 1'b0;
         o_ls_rdata  <= '0;
         o_ls_err    <= 1'b0;
      end else begin
         o_if_rvalid <= 1'b0;
         o_ls_rvalid <= 1'b0;
         if (state == IDLE) begin
            if (grant_ls) begin
               o_mem_req   <= 1'b1;
               o_mem_addr  <= i_ls_addr;
               o_mem_wen   <= i_ls_wen;
               o_mem_wdata <= i_ls_wdata;
               o_mem_wmask <= i_ls_wmask;
               owner_ls    <= 1'b1;
               last_ls     <= 1'b1;
               cnt         <= '0;
            end else if (grant_if) begin
               o_mem_req   <= 1'b1;
               o_mem_addr  <= i_if_addr;
               o_mem_wen   <= 1'b0;
               o_mem_wdata <= '0;
               o_mem_wmask <= '0;
               owner_ls    <= 1'b0;
               last_ls     <= 1'b0;
               cnt         <= '0;
            end
         end else begin
            cnt <= cnt + 1'b1;
            if (done) begin
               o_mem_req <= 1'b0;
               if (owner_ls) begin
                  o_ls_rvalid <= 1'b1;
                  o_ls_rdata  <= rsp_rdata;
                  o_ls_err    <= !i_mem_ack;
               end else begin
                  o_if_rvalid <= 1'b1;
                  o_if_rdata  <= rsp_rdata;
                  o_if_err    <= !i_mem_ack;
               end
            end
         end
      end
   end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Single-port memory arbiter and sequencer for the core.
- The instruction-fetch path (IF port) and the load/store path (LS port) share one external memory port through it.
- It grants one requester at a time, sequences exactly one outstanding transaction with variable memory latency, returns the response to the granted requester, and aborts transactions that exceed a timeout.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 64, data width; must be a multiple of 8
- LS_PRIO, 1, 1 = fixed priority to LS port; 0 = round-robin between IF and LS
- TIMEOUT, 255, max cycles o_mem_req may stay high without i_mem_ack; 0 disables the timeout

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_valid  in  1  IF request
- i_if_addr  in  ADDR_W  IF address (read only)
- o_if_ready  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF response pulse
- o_if_rdata  out  DATA_W  IF read data
- o_if_err  out  1  IF response is a timeout error (valid with o_if_rvalid)
- i_ls_valid  in  1  LS request
- i_ls_addr  in  ADDR_W  LS address
- i_ls_wen  in  1  1 = store, 0 = load
- i_ls_wdata  in  DATA_W  store data
- i_ls_wmask  in  DATA_W/8  store byte mask
- o_ls_ready  out  1  LS request accepted this cycle
- o_ls_rvalid  out  1  LS response pulse
- o_ls_rdata  out  DATA_W  LS read data
- o_ls_err  out  1  LS timeout error (valid with o_ls_rvalid)
- o_mem_req  out  1  memory request, held until ack
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wen  out  1  memory write enable
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_wmask  out  DATA_W/8  memory byte mask
- i_mem_ack  in  1  memory completion, one-cycle pulse
- i_mem_rdata  in  DATA_W  read data, valid when i_mem_ack=1

Behaviour:
- Clock and reset: one clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - All registered outputs are 0: o_mem_*, o_*_rvalid, o_*_rdata, o_*_err.
  - FSM = IDLE; timeout counter = 0; round-robin pointer = "IF last granted", so LS wins the first tie.
- FSM states: IDLE, BUSY.
- IDLE:
  - o_if_ready/o_ls_ready are combinational and assert only in IDLE, for the granted requester only.
  - Grant rule with LS_PRIO=1: LS if i_ls_valid, else IF.
  - Grant rule with LS_PRIO=0: if both are valid, grant the port not granted last; if one is valid, grant it.
  - On grant: register the payload into o_mem_* (IF forces wen=0, wdata=0, wmask=0), set o_mem_req=1, record the owner, clear the counter, go to BUSY.
  - In IDLE, i_mem_ack is ignored.
- BUSY:
  - o_mem_req and the payload are held stable; both ready outputs = 0; the counter increments each cycle.
  - On i_mem_ack: o_mem_req <= 0 and the owner's o_*_rvalid <= 1 for exactly one cycle.
    - Load or IF: o_*_rdata <= i_mem_rdata.
    - Store: o_*_rdata <= 0.
    - o_*_err <= 0; go to IDLE.
  - Timeout (TIMEOUT>0 and counter reaches TIMEOUT-1 with no ack): o_mem_req <= 0, owner's o_*_rvalid <= 1, o_*_err <= 1, rdata <= 0; go to IDLE.
  - If ack arrives in the same cycle as the timeout, ack wins (err=0).
- Latency:
  - Grant at cycle T; o_mem_req high from T+1.
  - Ack at cycle T+k (k>=1) gives rvalid at T+k+1.
  - The FSM is in IDLE at T+k+1, so a new grant may occur in the same cycle as rvalid. Back-to-back period = k+1 cycles.
- Requester rules:
  - A requester holds valid and payload until its ready is seen.
  - The payload is sampled only on the ready cycle.
  - Dropping valid without ready is legal; nothing is issued.
- Pulses: o_*_rvalid is a single-cycle pulse; o_*_rdata and o_*_err hold their value until the next response to that port.
- Round-robin pointer: updates only on grant.
- Reset mid-transaction: immediate return to IDLE with o_mem_req=0; the pending transaction is dropped and no rvalid is produced. The external memory must also be reset.
- Counter width: $clog2(TIMEOUT+1); it must not wrap before TIMEOUT.

Test Plan:
- IF-only read, addr 0x8000_0000, ack after 3 cycles with rdata 0x0000_0000_0010_0073:
  - o_if_ready at T, o_mem_req during T+1..T+3.
  - o_if_rvalid at T+4 with that rdata, o_if_err=0.
- Simultaneous IF and LS valid, LS_PRIO=1, LS store addr 0x100, wdata 0xDEAD_BEEF, wmask 0x0F:
  - LS granted first, with o_mem_wen=1 and mask 0x0F on the memory port.
  - o_ls_rvalid with rdata 0.
  - IF granted in the cycle of o_ls_rvalid.
- LS_PRIO=0, both valid continuously for 4 transactions, ack latency 1:
  - Grants alternate LS, IF, LS, IF.
  - Each response is 2 cycles after its grant.
- TIMEOUT=8, LS load with no ack:
  - o_mem_req is high for exactly 8 cycles.
  - o_ls_rvalid=1, o_ls_err=1, rdata 0; the next request is accepted afterwards.
- TIMEOUT=8, ack in the final timeout cycle: normal response, err=0.
- i_rst_n pulled low 2 cycles into a BUSY IF read:
  - o_mem_req=0 immediately; no rvalid after release.
  - The first post-reset tie is granted to LS.
  - A stray i_mem_ack in IDLE produces no response.
